npe_pool_acc: RTL and testbench

Multi-lane, parametrised window-reduction engine for the NPE datapath. It reduces a window of consecutive `i_mdata` beats per lane into one result. Supported reductions are max, min, sum and average, over signed lanes. It adds three capabilities: a programmable window length, early window close, and valid/ready backpressure on both sides. It sits between the feature-map buffer and the NPE result path, and produces `o_npe_result`-compatible 2×DATA_WIDTH lanes.

---
 rtl/npe_pool_acc.sv | 136 +++++++++++++
 tb/tb_npe_pool_acc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/npe_pool_acc.sv
// Multi-lane window reduction engine (max / avg / sum / min) with a programmable
// window length, early close via flush, and valid/ready handshakes on both sides.
module npe_pool_acc #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [1:0]                          i_mode,
    input  logic [CNT_WIDTH-1:0]                i_win_len,
    input  logic [2:0]                          i_avg_shift,
    input  logic [DATA_COPIES*DATA_WIDTH-1:0]   i_mdata,
    input  logic                                i_mdata_vld,
    output logic                                o_mdata_rdy,
    input  logic                                i_flush,
    output logic [DATA_COPIES*2*DATA_WIDTH-1:0] o_result,
    output logic                                o_result_vld,
    input  logic                                i_result_rdy,
    output logic [CNT_WIDTH-1:0]                o_win_cnt,
    output logic                                o_busy
);
    // state | meaning
    // IDLE  | waiting for the first beat of a window
    // ACC   | accumulating beats until win_len or flush
    // HOLD  | result presented, waiting for i_result_rdy
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    localparam int AW = 2 * DATA_WIDTH;
    localparam logic signed [AW:0] SUM_MAX = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0] SUM_MIN = {2'b11, {(AW-1){1'b0}}};
    localparam logic signed [AW:0] RND_ONE = (AW+1)'(1);

    state_t                state, state_nxt;
    logic                  rdy_q, vld_q;
    logic [1:0]            mode_q;
    logic [2:0]            shift_q;
    logic [CNT_WIDTH-1:0]  len_q, cnt;
    logic [DATA_COPIES*AW-1:0] result_q;

    logic                  fire, close;
    logic [1:0]            eff_mode;
    logic [2:0]            eff_shift;
    logic [CNT_WIDTH-1:0]  eff_len, cnt_inc;

    logic signed [AW-1:0]  acc     [DATA_COPIES];
    logic signed [AW-1:0]  xe      [DATA_COPIES];
    logic signed [AW-1:0]  upd     [DATA_COPIES];
    logic signed [AW-1:0]  sum_sat [DATA_COPIES];
    logic signed [AW-1:0]  acc_nxt [DATA_COPIES];
    logic signed [AW:0]    sum_w   [DATA_COPIES];
    logic signed [AW:0]    rnd     [DATA_COPIES];
    logic signed [AW:0]    rnd_sh  [DATA_COPIES];
    logic [DATA_COPIES*AW-1:0] res_pk;

    assign fire      = i_mdata_vld && rdy_q;
    assign eff_len   = (i_win_len == '0) ? CNT_WIDTH'(1) : i_win_len;
    assign cnt_inc   = cnt + CNT_WIDTH'(1);
    // Controls are taken live on the first beat so a one-beat window uses them too.
    assign eff_mode  = (state == S_IDLE) ? i_mode : mode_q;
    assign eff_shift = (state == S_IDLE) ? i_avg_shift : shift_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (fire) state_nxt = (eff_len == CNT_WIDTH'(1) || i_flush) ? S_HOLD : S_ACC;
            S_ACC:  if ((fire && cnt_inc == len_q) || i_flush) state_nxt = S_HOLD;
            S_HOLD: if (i_result_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != S_IDLE);
        close  = (state != S_HOLD) && (state_nxt == S_HOLD);
    end

    always_comb begin
        res_pk = '0;
        for (int k = 0; k < DATA_COPIES; k++) begin
            xe[k] = {{DATA_WIDTH{i_mdata[k*DATA_WIDTH+DATA_WIDTH-1]}}, i_mdata[k*DATA_WIDTH +: DATA_WIDTH]};
            sum_w[k] = {acc[k][AW-1], acc[k]} + {xe[k][AW-1], xe[k]};
            if (sum_w[k] > SUM_MAX)      sum_sat[k] = SUM_MAX[AW-1:0];
            else if (sum_w[k] < SUM_MIN) sum_sat[k] = SUM_MIN[AW-1:0];
            else                         sum_sat[k] = sum_w[k][AW-1:0];
            case (eff_mode)
                2'b00:   upd[k] = (xe[k] > acc[k]) ? xe[k] : acc[k];
                2'b11:   upd[k] = (xe[k] < acc[k]) ? xe[k] : acc[k];
                default: upd[k] = sum_sat[k];
            endcase
            if (!fire)                 acc_nxt[k] = acc[k];
            else if (state == S_IDLE)  acc_nxt[k] = xe[k];
            else                       acc_nxt[k] = upd[k];
            // Widened by one bit so the rounding offset cannot wrap near full scale.
            rnd[k]    = {acc_nxt[k][AW-1], acc_nxt[k]} + (RND_ONE << (eff_shift - 3'd1));
            rnd_sh[k] = rnd[k] >>> eff_shift;
            if (eff_mode == 2'b01 && eff_shift != 3'd0) res_pk[k*AW +: AW] = rnd_sh[k][AW-1:0];
            else                                        res_pk[k*AW +: AW] = acc_nxt[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            mode_q   <= 2'b00;
            shift_q  <= 3'd0;
            len_q    <= CNT_WIDTH'(1);
            cnt      <= '0;
            result_q <= '0;
            for (int k = 0; k < DATA_COPIES; k++) acc[k] <= '0;
        end else begin
            rdy_q <= (state_nxt != S_HOLD);
            vld_q <= (state_nxt == S_HOLD);
            if (fire && state == S_IDLE) begin
                mode_q  <= i_mode;
                shift_q <= i_avg_shift;
                len_q   <= eff_len;
            end
            if (fire)                              cnt <= (state == S_IDLE) ? CNT_WIDTH'(1) : cnt_inc;
            else if (state == S_HOLD && i_result_rdy) cnt <= '0;
            if (close) result_q <= res_pk;
            for (int k = 0; k < DATA_COPIES; k++) acc[k] <= acc_nxt[k];
        end
    end

    assign o_mdata_rdy  = rdy_q;
    assign o_result_vld = vld_q;
    assign o_result     = result_q;
    assign o_win_cnt    = cnt;
endmodule

// File: tb/tb_npe_pool_acc.sv
// Directed bench for npe_pool_acc: a default 8-bit instance plus a 4-bit/5-bit-count
// instance that can actually reach sum saturation.
module tb_npe_pool_acc;
    logic         clk = 1'b0;
    logic         rst, flush, mdata_vld, result_rdy;
    logic [1:0]   mode;
    logic [3:0]   win_len;
    logic [4:0]   win_len5;
    logic [2:0]   avg_shift;
    logic [255:0] mdata8;
    logic [127:0] mdata4;
    logic         rdy8, res_vld8, busy8, rdy4, res_vld4, busy4;
    logic [511:0] result8;
    logic [255:0] result4;
    logic [3:0]   cnt8;
    logic [4:0]   cnt4;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    npe_pool_acc dut8 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_win_len(win_len), .i_avg_shift(avg_shift),
        .i_mdata(mdata8), .i_mdata_vld(mdata_vld), .o_mdata_rdy(rdy8), .i_flush(flush),
        .o_result(result8), .o_result_vld(res_vld8), .i_result_rdy(result_rdy),
        .o_win_cnt(cnt8), .o_busy(busy8)
    );

    npe_pool_acc #(.DATA_WIDTH(4), .DATA_COPIES(32), .CNT_WIDTH(5)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_win_len(win_len5), .i_avg_shift(avg_shift),
        .i_mdata(mdata4), .i_mdata_vld(mdata_vld), .o_mdata_rdy(rdy4), .i_flush(flush),
        .o_result(result4), .o_result_vld(res_vld4), .i_result_rdy(result_rdy),
        .o_win_cnt(cnt4), .o_busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] r8(input int k);
        return result8[k*16 +: 16];
    endfunction

    function automatic logic [7:0] r4(input int k);
        return result4[k*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [3:0] len, input logic [2:0] sh);
        mode = m; win_len = len; win_len5 = {1'b0, len}; avg_shift = sh;
    endtask

    task automatic beat(input logic [7:0] a0, a1, a2, a31, input logic fl, input logic sel4);
        logic xfer;
        xfer = 1'b0;
        mdata8 = '0;
        mdata8[7:0] = a0; mdata8[15:8] = a1; mdata8[23:16] = a2; mdata8[255:248] = a31;
        mdata_vld = 1'b1;
        flush = fl;
        for (int i = 0; i < 20; i++) begin
            xfer = sel4 ? rdy4 : rdy8;
            tick();
            if (xfer) break;
        end
        if (!xfer) check("beat_timeout", 32'd0, 32'd1);
        mdata_vld = 1'b0;
        flush = 1'b0;
    endtask

    task automatic take();
        result_rdy = 1'b1;
        tick();
        result_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mdata_vld = 1'b0; result_rdy = 1'b0;
        cfg(2'b00, 4'd1, 3'd0);
        mdata8 = '0; mdata4 = '0;
        tick(); tick();
        check("rst_vld", res_vld8, 0);
        check("rst_result", r8(0), 0);
        check("rst_rdy", rdy8, 0);
        check("rst_cnt", cnt8, 0);
        check("rst_busy", busy8, 0);
        rst = 1'b0;
        tick();
        check("idle_rdy", rdy8, 1);

        // max, window of 4
        cfg(2'b00, 4'd4, 3'd0);
        beat(8'd1, 8'd0, 8'd0, 8'hFD, 0, 0);
        beat(8'd2, 8'd0, 8'd0, 8'hFF, 0, 0);
        beat(8'd4, 8'd0, 8'd0, 8'hF9, 0, 0);
        check("max_vld_early", res_vld8, 0);
        beat(8'd8, 8'd0, 8'd0, 8'hFE, 0, 0);
        check("max_vld", res_vld8, 1);
        check("max_lane0", r8(0), 16'd8);
        check("max_lane31", r8(31), 16'hFFFF);
        check("max_cnt", cnt8, 4);
        check("max_hold_rdy", rdy8, 0);
        take();
        check("max_done_vld", res_vld8, 0);
        check("max_done_cnt", cnt8, 0);
        check("max_done_busy", busy8, 0);

        // avg, shift 2; control changes mid-window are ignored
        cfg(2'b01, 4'd4, 3'd2);
        beat(8'd1, 8'hFF, 8'd2, 8'd0, 0, 0);
        cfg(2'b00, 4'd1, 3'd0);
        beat(8'd2, 8'hFF, 8'd2, 8'd0, 0, 0);
        beat(8'd3, 8'hFF, 8'd2, 8'd0, 0, 0);
        beat(8'd5, 8'hFE, 8'd2, 8'd0, 0, 0);
        check("avg_vld", res_vld8, 1);
        check("avg_lane0", r8(0), 16'd3);
        check("avg_lane1", r8(1), 16'hFFFF);
        check("avg_lane2", r8(2), 16'd2);
        take();

        // sum of 15 x 127; narrow instance 15 x 7 and 15 x -8 stay in range
        cfg(2'b10, 4'd15, 3'd0);
        mdata4 = '0; mdata4[3:0] = 4'h7; mdata4[7:4] = 4'h8;
        for (int i = 0; i < 15; i++) beat(8'h7F, 8'd0, 8'd0, 8'd0, 0, 0);
        check("sum_lane0", r8(0), 16'h0771);
        check("sum4_vld", res_vld4, 1);
        check("sum4_lane0", r4(0), 8'h69);
        check("sum4_lane1", r4(1), 8'h88);
        take();

        // narrow instance, 31 beats: 31 x 7 and 31 x -8 clamp both ways
        cfg(2'b10, 4'd15, 3'd0);
        win_len5 = 5'd31;
        result_rdy = 1'b1;
        for (int i = 0; i < 31; i++) beat(8'd0, 8'd0, 8'd0, 8'd0, 0, 1);
        check("sat4_vld", res_vld4, 1);
        check("sat4_pos", r4(0), 8'h7F);
        check("sat4_neg", r4(1), 8'h80);
        check("sat4_cnt", cnt4, 31);
        result_rdy = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; tick();

        // signed min
        cfg(2'b11, 4'd3, 3'd0);
        beat(8'd5, 8'd0, 8'd0, 8'd0, 0, 0);
        beat(8'h80, 8'd0, 8'd0, 8'd0, 0, 0);
        beat(8'd3, 8'd0, 8'd0, 8'd0, 0, 0);
        check("min_lane0", r8(0), 16'hFF80);
        take();

        // flush alone after three beats
        cfg(2'b10, 4'd8, 3'd0);
        for (int i = 0; i < 3; i++) beat(8'd1, 8'd0, 8'd0, 8'd0, 0, 0);
        check("flush_pre_vld", res_vld8, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_vld", res_vld8, 1);
        check("flush_result", r8(0), 16'd3);
        check("flush_cnt", cnt8, 3);
        take();

        // flush together with the third beat
        beat(8'd1, 8'd0, 8'd0, 8'd0, 0, 0);
        beat(8'd1, 8'd0, 8'd0, 8'd0, 0, 0);
        beat(8'd1, 8'd0, 8'd0, 8'd0, 1, 0);
        check("flushb_vld", res_vld8, 1);
        check("flushb_result", r8(0), 16'd3);
        check("flushb_cnt", cnt8, 3);
        take();

        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_idle_busy", busy8, 0);

        // backpressure with extra beats offered during HOLD
        cfg(2'b10, 4'd2, 3'd0);
        beat(8'd4, 8'd0, 8'd0, 8'd0, 0, 0);
        beat(8'd5, 8'd0, 8'd0, 8'd0, 0, 0);
        mdata8 = '0; mdata8[7:0] = 8'd100; mdata_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_result", r8(0), 16'd9);
            check("bp_rdy", rdy8, 0);
            check("bp_cnt", cnt8, 2);
            check("bp_vld", res_vld8, 1);
        end
        mdata_vld = 1'b0;
        take();
        check("bp_rel_vld", res_vld8, 0);
        check("bp_rel_cnt", cnt8, 0);
        check("bp_rel_rdy", rdy8, 1);
        cfg(2'b10, 4'd1, 3'd0);
        beat(8'd6, 8'd0, 8'd0, 8'd0, 0, 0);
        check("bp_next_result", r8(0), 16'd6);
        check("bp_next_cnt", cnt8, 1);
        take();

        // reset mid-window
        cfg(2'b10, 4'd4, 3'd0);
        beat(8'd1, 8'd0, 8'd0, 8'd0, 0, 0);
        beat(8'd2, 8'd0, 8'd0, 8'd0, 0, 0);
        check("mid_cnt", cnt8, 2);
        rst = 1'b1; tick();
        check("mid_rst_vld", res_vld8, 0);
        check("mid_rst_result", r8(0), 0);
        check("mid_rst_cnt", cnt8, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_rdy", rdy8, 0);
        rst = 1'b0; tick();
        check("post_rst_cnt", cnt8, 0);
        beat(8'd1, 8'd0, 8'd0, 8'd0, 0, 0);
        check("post_rst_cnt1", cnt8, 1);
        for (int i = 0; i < 3; i++) beat(8'd1, 8'd0, 8'd0, 8'd0, 0, 0);
        check("post_rst_result", r8(0), 16'd4);
        take();

        // win_len 0 behaves as 1
        cfg(2'b10, 4'd0, 3'd0);
        beat(8'd9, 8'd0, 8'd0, 8'd0, 0, 0);
        check("len0_vld", res_vld8, 1);
        check("len0_result", r8(0), 16'd9);
        take();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
